serial_addsub_moore: RTL
========================

Name: serial_addsub_moore

Overview:
Parametrised, multi-lane, LSB-first serial adder/subtractor with a Moore output per lane. Next generation of the 2-bit Moore serial adder:
- adds word framing (start/in_valid) and add/subtract mode
- produces end-of-word carry, overflow and done
Used wherever the datapath carries operands bit-serially between serialiser and deserialiser stages.

Parameters:
WORD_BITS, 8, operand width in bits; legal range 2..64.
LANES, 1, number of independent lanes sharing framing and mode; legal range 1..16.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  a/b bits valid this cycle
start  in  1  qualified by in_valid; marks bit 0 (LSB) of a new word
sub  in  1  mode, sampled only on a start beat: 0 = a+b, 1 = a-b
a  in  LANES  operand A serial bit per lane
b  in  LANES  operand B serial bit per lane
q  out  2*LANES  per-lane Moore state {carry,sum}; lane i at [2i+1:2i]
y  out  LANES  sum/difference bit per lane; y[i] = q[2i]
y_valid  out  1  y carries a result bit
last  out  1  y_valid beat that holds the MSB
busy  out  1  a word is in progress
done  out  1  one-cycle pulse, coincident with last
cout  out  LANES  final carry-out; valid while done=1, held until next done
ovf  out  LANES  two's-complement overflow; valid while done=1, held until next done

Behaviour:
- Reset (synchronous, active-high, any cycle, including mid-word): q=0, y=0, y_valid=0, last=0, busy=0, done=0, cout=0, ovf=0, bit counter=0, mode=0. Partial word is discarded; no done is produced for it.
- Per-lane Moore states:
  - S0 {c0,s0} = 00
  - S1 {c0,s1} = 01
  - S2 {c1,s0} = 10
  - S3 {c1,s1} = 11
  - Output is a function of state only.
- Transition on an accepted beat (in_valid=1, and either start=1 or busy=1):
  - bb = b ^ mode
  - cin = start ? sub : q.carry
  - next sum = a ^ bb ^ cin
  - next carry = maj(a, bb, cin)
  - On a start beat, mode <= sub.
- Latency: the result bit for a beat accepted at edge n is on y from edge n+1. y_valid is in_valid delayed one cycle, gated by acceptance.
- Bit counter:
  - start beat: counter set to 1 and busy=1.
  - Other accepted beats: counter increments.
  - Beat WORD_BITS-1 accepted: counter wraps to 0, busy=0.
  - Next cycle: last=1 and done=1 for one cycle.
- Carry into MSB: each lane registers the carry state in force before the MSB beat.
  - ovf = carry_into_msb ^ next carry
  - cout = final carry
  - In subtract mode, cout=1 means no borrow.
- Stalls: in_valid=0 while busy → state, counter and y hold; y_valid=0.
- Beats while idle: in_valid=1, start=0, busy=0 → ignored; y_valid=0.
- start while busy: aborts the current word and begins a new word from this beat. No done for the aborted word; cout/ovf keep their previous values.
- start coinciding with the MSB beat: start wins; this is an abort plus restart.
- A new word may start on the cycle after the MSB beat, i.e. back-to-back words with no gap. done/last for the previous word then coincide with y_valid of bit 0 of the new word.

Decomposition:
- Package serial_addsub_pkg:
  - state encoding localparams S0..S3
  - CARRY_BIT = 1, SUM_BIT = 0
  - function next_state(a, bb, cin)
  - counter width = $clog2(WORD_BITS)
- Sub-module serial_addsub_lane: one Moore FSM per lane.
  - Inputs: a, b, mode, start, accept.
  - Outputs: q, carry_into_msb capture, cout/ovf on the MSB beat.
- Top level owns the counter, busy, y_valid, last, done, mode register, and the generate loop over LANES.

Test Plan:
- WORD_BITS=8, LANES=1, add 0x35+0x1A, contiguous beats → y LSB-first = 0x4F; done one cycle after the MSB beat; cout=0, ovf=0.
- Subtract 0x10-0x01 → y=0x0F, cout=1, ovf=0. Then add 0xFF+0x01 → y=0x00, cout=1, ovf=0.
- Add 0x7F+0x01 with in_valid dropped for 3 cycles after bit 3 → y=0x80, ovf=1, cout=0. During the gap y_valid=0 and q holds; done arrives exactly 3 cycles later than the contiguous case.
- Start 0x35+0x1A, reassert start at bit 4 with 0x02+0x03 → no done for the first word; y=0x05 and a single done for the second word. Reset asserted mid-word → all outputs 0 on the next edge.
- LANES=2, lane0 0x7F+0x01, lane1 0x80-0x01, back-to-back with a second word 0x01+0x01 on both lanes:
  - word 1: lane0 y=0x80, ovf=1; lane1 y=0x7F, ovf=1, cout=1
  - word 2: y=0x02 on both lanes
  - done pulses exactly twice, 8 cycles apart.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Each lane state is {carry, sum}, which is also the Moore output.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } lane_state_t;

   localparam int CARRY_BIT = 1;
   localparam int SUM_BIT   = 0;

   // Full-adder step from the current operand bits and incoming carry.
   function automatic lane_state_t next_state(input logic a, input logic bb, input logic cin);
      logic s;
      logic c;
      s = a ^ bb ^ cin;
      c = (a & bb) | (a & cin) | (bb & cin);
      return lane_state_t'({c, s});
   endfunction

   function automatic int cnt_width(input int word_bits);
      return (word_bits < 2) ? 1 : $clog2(word_bits);
   endfunction

endpackage

// File: rtl/serial_addsub_lane.sv
// One Moore FSM per lane: carry/sum state, with end-of-word carry-out
// and overflow captured on the MSB beat.
module serial_addsub_lane
   import serial_addsub_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   input  logic       mode,
   input  logic       start,
   input  logic       accept,
   input  logic       msb_beat,
   output logic [1:0] q,
   output logic       cout,
   output logic       ovf
);

   lane_state_t state_reg;
   lane_state_t state_next;
   lane_state_t step;
   logic        bb;
   logic        cin;
   logic        cout_reg;
   logic        ovf_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S0;
      end else begin
         state_reg <= state_next;
      end
   end

   // A start beat ignores the stale carry: subtraction seeds cin with 1.
   always_comb begin
      bb         = b ^ mode;
      cin        = start ? mode : state_reg[CARRY_BIT];
      step       = next_state(a, bb, cin);
      state_next = state_reg;
      if (accept) begin
         state_next = step;
      end
   end

   // Carry into the MSB is the carry held in state just before the MSB beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (msb_beat) begin
         cout_reg <= step[CARRY_BIT];
         ovf_reg  <= state_reg[CARRY_BIT] ^ step[CARRY_BIT];
      end
   end

   assign q    = state_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: rtl/serial_addsub_moore.sv
// Multi-lane LSB-first serial adder/subtractor: shared word framing, mode
// register and bit counter, with one Moore lane FSM per operand pair.
module serial_addsub_moore
   import serial_addsub_pkg::*;
#(
   parameter int WORD_BITS = 8,
   parameter int LANES     = 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               start,
   input  logic               sub,
   input  logic [LANES-1:0]   a,
   input  logic [LANES-1:0]   b,
   output logic [2*LANES-1:0] q,
   output logic [LANES-1:0]   y,
   output logic               y_valid,
   output logic               last,
   output logic               busy,
   output logic               done,
   output logic [LANES-1:0]   cout,
   output logic [LANES-1:0]   ovf
);

   localparam int             CNT_W   = cnt_width(WORD_BITS);
   localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WORD_BITS - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             busy_reg;
   logic             busy_next;
   logic             mode_reg;
   logic             mode_next;
   logic             y_valid_reg;
   logic             last_reg;
   logic             accept;
   logic             msb_beat;
   logic             mode_eff;

   // A start beat is always taken and wins over an MSB beat in the same cycle.
   assign accept   = in_valid & (start | busy_reg);
   assign msb_beat = accept & ~start & (cnt_reg == MSB_IDX);
   assign mode_eff = start ? sub : mode_reg;

   always_comb begin
      cnt_next  = cnt_reg;
      busy_next = busy_reg;
      mode_next = mode_reg;
      if (in_valid && start) begin
         cnt_next  = CNT_W'(1);
         busy_next = 1'b1;
         mode_next = sub;
      end else if (msb_beat) begin
         cnt_next  = '0;
         busy_next = 1'b0;
      end else if (accept) begin
         cnt_next  = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg     <= '0;
         busy_reg    <= 1'b0;
         mode_reg    <= 1'b0;
         y_valid_reg <= 1'b0;
         last_reg    <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         busy_reg    <= busy_next;
         mode_reg    <= mode_next;
         y_valid_reg <= accept;
         last_reg    <= msb_beat;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      serial_addsub_lane u_lane (
         .clk      (clk),
         .reset    (reset),
         .a        (a[gi]),
         .b        (b[gi]),
         .mode     (mode_eff),
         .start    (start),
         .accept   (accept),
         .msb_beat (msb_beat),
         .q        (q[2*gi+1:2*gi]),
         .cout     (cout[gi]),
         .ovf      (ovf[gi])
      );
      assign y[gi] = q[2*gi+SUM_BIT];
   end

   assign y_valid = y_valid_reg;
   assign last    = last_reg;
   assign done    = last_reg;
   assign busy    = busy_reg;

endmodule
